// File: rtl/spi_packet_assembler.sv
// -----------------------------------------------------------------------------
// spi_packet_assembler
//
// Sits behind the SPI receive FIFO in the system clock domain. Pops tagged
// 32-bit words and groups them into frame, polygon and camera packets. Each
// complete packet is presented on one wide bus with a valid/ready handshake.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   fifo_dout     FIFO read data, valid one clk after fifo_rd_en
//   fifo_type     type tag travelling with fifo_dout (01 frame, 10 poly, 11 cam)
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO pop strobe (never asserted while fifo_empty is high)
//   pkt_valid     complete packet available
//   pkt_ready     consumer accepts the packet on pkt_valid && pkt_ready
//   pkt_type      type of the presented packet
//   pkt_words     number of valid words in pkt_data
//   pkt_data      packet words, word 0 in the MSBs, unused words zero
//   err_pulse     one-clk pulse on a protocol error
//   err_code      last error (01 null word, 10 type change, 11 timeout), held
//
// Optional feature: define PKT_TIMEOUT_EN to add a watchdog that drops a
// partial packet after TIMEOUT_CYCLES idle clocks.
// -----------------------------------------------------------------------------
module spi_packet_assembler #(
    parameter int DATA_W      = 32,
    parameter int FRAME_WORDS = 1,
    parameter int POLY_WORDS  = 13,
    parameter int CAM_WORDS   = 3,
    parameter int MAX_WORDS   = 13
`ifdef PKT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65536
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           fifo_dout,
    input  logic [1:0]                  fifo_type,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic [1:0]                  pkt_type,
    output logic [3:0]                  pkt_words,
    output logic [MAX_WORDS*DATA_W-1:0] pkt_data,
    output logic                        err_pulse,
    output logic [1:0]                  err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PEND,
        S_OUT
    } state_t;

    localparam logic [1:0] T_NULL  = 2'b00;
    localparam logic [1:0] T_FRAME = 2'b01;
    localparam logic [1:0] T_POLY  = 2'b10;
    localparam logic [1:0] T_CAM   = 2'b11;

    function automatic logic [3:0] type_len(input logic [1:0] t);
        case (t)
            T_FRAME: type_len = 4'(FRAME_WORDS);
            T_POLY:  type_len = 4'(POLY_WORDS);
            T_CAM:   type_len = 4'(CAM_WORDS);
            default: type_len = 4'd0;
        endcase
    endfunction

    state_t            state;
    state_t            next_state;
    logic [3:0]        idx;
    logic [1:0]        cur_type;
    logic [DATA_W-1:0] data_q [MAX_WORDS];
    logic              err_pulse_q;
    logic [1:0]        err_code_q;
    logic              timeout_hit;

    // Classification of the word sitting on fifo_dout while in LATCH.
    // A type change mid-packet restarts the packet with this word in slot 0.
    logic       is_null;
    logic       is_switch;
    logic [3:0] slot;
    logic       word_last;

    always_comb begin
        is_null   = (fifo_type == T_NULL);
        is_switch = !is_null && (idx != 4'd0) && (fifo_type != cur_type);
        slot      = is_switch ? 4'd0 : idx;
        word_last = !is_null && (slot == type_len(fifo_type) - 4'd1);
    end

`ifdef PKT_TIMEOUT_EN
    // Watchdog: runs only while a partial packet is waiting for its next word.
    logic [16:0] wd;

    assign timeout_hit = (state == S_PEND) && (wd == 17'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state == S_LATCH || idx == 4'd0 || timeout_hit) begin
            wd <= '0;
        end else if (state != S_OUT) begin
            wd <= wd + 17'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_PEND: begin
                if (timeout_hit) begin
                    next_state = S_IDLE;
                end else if (!fifo_empty) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: next_state = S_LATCH;
            S_LATCH: begin
                if (word_last) begin
                    next_state = S_OUT;
                end else if (!fifo_empty) begin
                    next_state = S_FETCH;
                end else if (is_null && idx == 4'd0) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = S_PEND;
                end
            end
            S_OUT: begin
                if (pkt_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Pops come from the waiting states or straight out of LATCH when the
    // packet still needs more words; nothing is popped while a packet is held.
    always_comb begin
        fifo_rd_en = 1'b0;
        pkt_valid  = (state == S_OUT);
        pkt_type   = 2'b00;
        pkt_words  = 4'd0;
        pkt_data   = '0;
        if (!rst && !fifo_empty) begin
            if ((state == S_IDLE || state == S_PEND) && !timeout_hit) begin
                fifo_rd_en = 1'b1;
            end else if (state == S_LATCH && !word_last) begin
                fifo_rd_en = 1'b1;
            end
        end
        if (state == S_OUT) begin
            pkt_type  = cur_type;
            pkt_words = type_len(cur_type);
            for (int i = 0; i < MAX_WORDS; i++) begin
                pkt_data[(MAX_WORDS-i)*DATA_W-1 -: DATA_W] = data_q[i];
            end
        end
    end

    // Datapath: slot capture, index, packet type and error reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= 4'd0;
            cur_type    <= 2'b00;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'b00;
            for (int i = 0; i < MAX_WORDS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            err_pulse_q <= 1'b0;
            case (state)
                S_LATCH: begin
                    if (is_null) begin
                        err_pulse_q <= 1'b1;
                        err_code_q  <= 2'b01;
                    end else begin
                        if (is_switch) begin
                            err_pulse_q <= 1'b1;
                            err_code_q  <= 2'b10;
                            for (int i = 0; i < MAX_WORDS; i++) begin
                                data_q[i] <= '0;
                            end
                        end
                        if (int'(slot) < MAX_WORDS) begin
                            data_q[slot] <= fifo_dout;
                        end
                        cur_type <= fifo_type;
                        if (!word_last) begin
                            idx <= slot + 4'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (pkt_ready) begin
                        idx <= 4'd0;
                        for (int i = 0; i < MAX_WORDS; i++) begin
                            data_q[i] <= '0;
                        end
                    end
                end
                S_PEND: begin
                    if (timeout_hit) begin
                        idx         <= 4'd0;
                        err_pulse_q <= 1'b1;
                        err_code_q  <= 2'b11;
                        for (int i = 0; i < MAX_WORDS; i++) begin
                            data_q[i] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_spi_packet_assembler.sv
// -----------------------------------------------------------------------------
// tb_spi_packet_assembler
//
// Directed bench for spi_packet_assembler. A small queue-based FIFO model
// feeds the DUT with one clk read latency; packets, error pulses and pop
// counts are checked against hand-computed values.
// With PKT_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES = 100 and
// the watchdog step runs as well.
// -----------------------------------------------------------------------------
module tb_spi_packet_assembler;

    localparam int DW  = 32;
    localparam int MW  = 13;
    localparam int BUS = MW * DW;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  fifo_dout;
    logic [1:0]     fifo_type;
    logic           fifo_empty;
    logic           fifo_rd_en;
    logic           pkt_valid;
    logic           pkt_ready;
    logic [1:0]     pkt_type;
    logic [3:0]     pkt_words;
    logic [BUS-1:0] pkt_data;
    logic           err_pulse;
    logic [1:0]     err_code;

    logic [33:0]    fifo_q [$];
    logic           gate;
    logic           gate_toggle;
    int             pop_count;
    int             err_seen;
    logic [1:0]     last_err;
    int             checks;
    int             passed;

    logic [BUS-1:0] exp_bus;
    logic [BUS-1:0] saved_bus;
    int             saved_pops;

    always #5 clk = ~clk;

`ifdef PKT_TIMEOUT_EN
    spi_packet_assembler #(.TIMEOUT_CYCLES(100)) dut (
`else
    spi_packet_assembler dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_type  (fifo_type),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_type   (pkt_type),
        .pkt_words  (pkt_words),
        .pkt_data   (pkt_data),
        .err_pulse  (err_pulse),
        .err_code   (err_code)
    );

    task automatic check_output(input string tag, input logic [BUS-1:0] obs,
                                input logic [BUS-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // FIFO model: data appears one clk after the pop strobe.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            check_output("rd_en_while_empty", BUS'(fifo_empty), BUS'(0));
            if (fifo_q.size() > 0) begin
                fifo_type <= fifo_q[0][33:32];
                fifo_dout <= fifo_q[0][31:0];
                void'(fifo_q.pop_front());
                pop_count++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (err_pulse) begin
            err_seen++;
            last_err = err_code;
        end
        if (gate_toggle) gate = ~gate;
        fifo_empty = (fifo_q.size() == 0) || gate;
    endtask

    task automatic apply_stimulus(input logic [1:0] t, input logic [31:0] d);
        fifo_q.push_back({t, d});
    endtask

    task automatic wait_pkt(input string tag, input int limit);
        for (int n = 0; n < limit && !pkt_valid; n++) step();
        check_output(tag, BUS'(pkt_valid), BUS'(1));
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        exp_bus[BUS-1-32*i -: 32] = w;
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        pop_count   = 0;
        err_seen    = 0;
        last_err    = 2'b00;
        gate        = 1'b0;
        gate_toggle = 1'b0;
        rst         = 1'b1;
        pkt_ready   = 1'b0;
        fifo_empty  = 1'b1;
        fifo_dout   = '0;
        fifo_type   = 2'b00;

        // Reset state
        step();
        step();
        check_output("rst_valid", BUS'(pkt_valid), BUS'(0));
        check_output("rst_type", BUS'(pkt_type), BUS'(0));
        check_output("rst_words", BUS'(pkt_words), BUS'(0));
        check_output("rst_data", pkt_data, BUS'(0));
        check_output("rst_err_pulse", BUS'(err_pulse), BUS'(0));
        check_output("rst_err_code", BUS'(err_code), BUS'(0));
        check_output("rst_rd_en", BUS'(fifo_rd_en), BUS'(0));
        rst = 1'b0;
        step();

        // Single frame word
        pkt_ready = 1'b1;
        apply_stimulus(2'b01, 32'hDEADBEEF);
        wait_pkt("t1_valid", 50);
        exp_bus = '0;
        set_word(0, 32'hDEADBEEF);
        check_output("t1_type", BUS'(pkt_type), BUS'(2'b01));
        check_output("t1_words", BUS'(pkt_words), BUS'(1));
        check_output("t1_data", pkt_data, exp_bus);
        step();
        check_output("t1_valid_one_clk", BUS'(pkt_valid), BUS'(0));
        check_output("t1_no_err", BUS'(err_seen), BUS'(0));

        // Camera packet held under backpressure, a frame waiting behind it
        pkt_ready  = 1'b0;
        saved_pops = pop_count;
        apply_stimulus(2'b11, 32'h11111111);
        apply_stimulus(2'b11, 32'h22222222);
        apply_stimulus(2'b11, 32'h33333333);
        apply_stimulus(2'b01, 32'hCAFEF00D);
        wait_pkt("t2_valid", 60);
        exp_bus = '0;
        set_word(0, 32'h11111111);
        set_word(1, 32'h22222222);
        set_word(2, 32'h33333333);
        check_output("t2_type", BUS'(pkt_type), BUS'(2'b11));
        check_output("t2_words", BUS'(pkt_words), BUS'(3));
        check_output("t2_data", pkt_data, exp_bus);
        check_output("t2_pops", BUS'(pop_count - saved_pops), BUS'(3));
        repeat (20) step();
        check_output("t2_held_valid", BUS'(pkt_valid), BUS'(1));
        check_output("t2_held_data", pkt_data, exp_bus);
        check_output("t2_stall_pops", BUS'(pop_count - saved_pops), BUS'(3));
        pkt_ready = 1'b1;
        step();
        check_output("t2_accepted", BUS'(pkt_valid), BUS'(0));
        check_output("t2_cleared", pkt_data, BUS'(0));
        wait_pkt("t2_frame_valid", 50);
        exp_bus = '0;
        set_word(0, 32'hCAFEF00D);
        check_output("t2_frame_type", BUS'(pkt_type), BUS'(2'b01));
        check_output("t2_frame_data", pkt_data, exp_bus);
        step();

        // Polygon packet with a stuttering empty flag
        saved_pops  = pop_count;
        gate_toggle = 1'b1;
        exp_bus     = '0;
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(2'b10, 32'hA0000000 + 32'(i));
            set_word(i, 32'hA0000000 + 32'(i));
        end
        wait_pkt("t3_valid", 300);
        check_output("t3_type", BUS'(pkt_type), BUS'(2'b10));
        check_output("t3_words", BUS'(pkt_words), BUS'(13));
        check_output("t3_data", pkt_data, exp_bus);
        check_output("t3_pops", BUS'(pop_count - saved_pops), BUS'(13));
        gate_toggle = 1'b0;
        gate        = 1'b0;
        step();
        check_output("t3_no_err", BUS'(err_seen), BUS'(0));

        // Type change mid-packet
        err_seen = 0;
        apply_stimulus(2'b10, 32'h50000001);
        apply_stimulus(2'b10, 32'h50000002);
        apply_stimulus(2'b11, 32'hC0000001);
        apply_stimulus(2'b11, 32'hC0000002);
        apply_stimulus(2'b11, 32'hC0000003);
        wait_pkt("t4_valid", 100);
        exp_bus = '0;
        set_word(0, 32'hC0000001);
        set_word(1, 32'hC0000002);
        set_word(2, 32'hC0000003);
        check_output("t4_type", BUS'(pkt_type), BUS'(2'b11));
        check_output("t4_words", BUS'(pkt_words), BUS'(3));
        check_output("t4_data", pkt_data, exp_bus);
        check_output("t4_err_count", BUS'(err_seen), BUS'(1));
        check_output("t4_err_code", BUS'(last_err), BUS'(2'b10));
        step();

        // Null-type word inside a camera packet
        err_seen = 0;
        apply_stimulus(2'b11, 32'hD0000001);
        apply_stimulus(2'b00, 32'hBADBAD00);
        apply_stimulus(2'b11, 32'hD0000002);
        apply_stimulus(2'b11, 32'hD0000003);
        wait_pkt("t5_valid", 100);
        exp_bus = '0;
        set_word(0, 32'hD0000001);
        set_word(1, 32'hD0000002);
        set_word(2, 32'hD0000003);
        check_output("t5_words", BUS'(pkt_words), BUS'(3));
        check_output("t5_data", pkt_data, exp_bus);
        check_output("t5_err_count", BUS'(err_seen), BUS'(1));
        check_output("t5_err_code", BUS'(last_err), BUS'(2'b01));
        step();
        check_output("t5_err_code_held", BUS'(err_code), BUS'(2'b01));

        // Reset in the middle of a polygon packet
        saved_pops = pop_count;
        apply_stimulus(2'b10, 32'h70000001);
        apply_stimulus(2'b10, 32'h70000002);
        repeat (12) step();
        check_output("t6_partial_pops", BUS'(pop_count - saved_pops), BUS'(2));
        rst = 1'b1;
        step();
        check_output("t6_rst_valid", BUS'(pkt_valid), BUS'(0));
        check_output("t6_rst_err_code", BUS'(err_code), BUS'(0));
        check_output("t6_rst_rd_en", BUS'(fifo_rd_en), BUS'(0));
        rst      = 1'b0;
        err_seen = 0;
        apply_stimulus(2'b01, 32'h12345678);
        wait_pkt("t6_frame_valid", 50);
        exp_bus = '0;
        set_word(0, 32'h12345678);
        check_output("t6_frame_type", BUS'(pkt_type), BUS'(2'b01));
        check_output("t6_frame_data", pkt_data, exp_bus);
        check_output("t6_no_err", BUS'(err_seen), BUS'(0));
        step();

`ifdef PKT_TIMEOUT_EN
        // Watchdog drops a stalled partial packet
        err_seen = 0;
        apply_stimulus(2'b10, 32'h90000001);
        for (int n = 0; n < 300 && err_seen == 0; n++) step();
        check_output("t7_err_count", BUS'(err_seen), BUS'(1));
        check_output("t7_err_code", BUS'(last_err), BUS'(2'b11));
        check_output("t7_no_pkt", BUS'(pkt_valid), BUS'(0));
        apply_stimulus(2'b01, 32'h0F0F0F0F);
        wait_pkt("t7_frame_valid", 50);
        exp_bus = '0;
        set_word(0, 32'h0F0F0F0F);
        check_output("t7_frame_type", BUS'(pkt_type), BUS'(2'b01));
        check_output("t7_frame_data", pkt_data, exp_bus);
        step();
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
